// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - issue/sequencing controller between EX and the multi-cycle mul/div unit
//
// Accepts one RV M-extension request, drives the MDU with a held one-hot op and
// registered operands, waits for the MDU to go busy and come back ready, and
// returns the result with backpressure. Divide-by-zero is answered locally.
// flush aborts everything; a watchdog aborts a stuck MDU.
//
// Ports:
//   clock, reset (async, active-low), flush
//   req_*  : request channel (valid/ready, funct3 op, operands, tag)
//   resp_* : response channel (valid/ready, result, tag, err = watchdog abort)
//   m_*    : MDU side (one-hot op, operands, cancel pulse, ready level, result)

module mdu_ctrl #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5,
   parameter int WDOG  = 255
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [XLEN-1:0]  req_src1,
   input  logic [XLEN-1:0]  req_src2,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_result,
   output logic [TAG_W-1:0] resp_tag,
   output logic             resp_err,
   output logic [7:0]       m_op,
   output logic [XLEN-1:0]  m_src1,
   output logic [XLEN-1:0]  m_src2,
   output logic             m_flush,
   input  logic             m_ready,
   input  logic [XLEN-1:0]  m_result
);

   typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;

   localparam logic [7:0] WDOG_CNT = WDOG[7:0];

   state_t           state_q, state_d;
   logic             req_ready_q, req_ready_d;
   logic             resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             err_q, err_d;
   logic [7:0]       op_q, op_d;
   logic [XLEN-1:0]  src1_q, src1_d;
   logic [XLEN-1:0]  src2_q, src2_d;
   logic             m_flush_q, m_flush_d;
   logic [7:0]       wdog_q, wdog_d;

   logic req_take;
   logic div_zero;

   // A request arriving together with flush is dropped outright.
   assign req_take = req_valid & req_ready_q & ~flush;
   // funct3[2] selects the divide group.
   assign div_zero = req_op[2] & (req_src2 == '0);

   always_comb begin
      state_d      = state_q;
      resp_valid_d = resp_valid_q;
      result_d     = result_q;
      tag_d        = tag_q;
      err_d        = err_q;
      op_d         = op_q;
      src1_d       = src1_q;
      src2_d       = src2_q;
      m_flush_d    = 1'b0;
      wdog_d       = wdog_q;

      case (state_q)
         IDLE: begin
            if (req_take) begin
               src1_d = req_src1;
               src2_d = req_src2;
               tag_d  = req_tag;
               err_d  = 1'b0;
               wdog_d = 8'd0;
               if (div_zero) begin
                  // funct3[1] distinguishes rem/remu (dividend) from div/divu (all ones).
                  result_d     = req_op[1] ? req_src1 : '1;
                  resp_valid_d = 1'b1;
                  state_d      = RESP;
               end else begin
                  op_d    = 8'd1 << req_op;
                  state_d = LAUNCH;
               end
            end
         end

         LAUNCH, BUSY: begin
            if (state_q == BUSY && m_ready) begin
               // Completion wins over a watchdog expiry in the same cycle.
               result_d     = m_result;
               op_d         = 8'd0;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else if (wdog_q == WDOG_CNT) begin
               m_flush_d    = 1'b1;
               op_d         = 8'd0;
               err_d        = 1'b1;
               result_d     = '0;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else begin
               wdog_d = wdog_q + 8'd1;
               // Completion is only trusted after the MDU has been seen busy.
               if (state_q == LAUNCH && !m_ready) begin
                  state_d = BUSY;
               end
            end
         end

         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d      = IDLE;
         resp_valid_d = 1'b0;
         op_d         = 8'd0;
         m_flush_d    = (state_q == LAUNCH) || (state_q == BUSY);
      end

      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         result_q     <= '0;
         tag_q        <= '0;
         err_q        <= 1'b0;
         op_q         <= 8'd0;
         src1_q       <= '0;
         src2_q       <= '0;
         m_flush_q    <= 1'b0;
         wdog_q       <= 8'd0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         result_q     <= result_d;
         tag_q        <= tag_d;
         err_q        <= err_d;
         op_q         <= op_d;
         src1_q       <= src1_d;
         src2_q       <= src2_d;
         m_flush_q    <= m_flush_d;
         wdog_q       <= wdog_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_result = result_q;
   assign resp_tag    = tag_q;
   assign resp_err    = err_q;
   assign m_op        = op_q;
   assign m_src1      = src1_q;
   assign m_src2      = src2_q;
   assign m_flush     = m_flush_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl with a behavioural MDU and reference model

module tb_mdu_ctrl;

   localparam int XLEN  = 64;
   localparam int TAG_W = 5;
   localparam int WDOG  = 255;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             flush = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [2:0]       req_op = 3'd0;
   logic [XLEN-1:0]  req_src1 = '0;
   logic [XLEN-1:0]  req_src2 = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             resp_valid;
   logic             resp_ready = 1'b1;
   logic [XLEN-1:0]  resp_result;
   logic [TAG_W-1:0] resp_tag;
   logic             resp_err;
   logic [7:0]       m_op;
   logic [XLEN-1:0]  m_src1;
   logic [XLEN-1:0]  m_src2;
   logic             m_flush;
   logic             mdu_ready;
   logic [XLEN-1:0]  mdu_result;

   int checks   = 0;
   int failures = 0;

   int mdu_lat   = 4;
   bit mdu_stuck = 1'b0;
   int mdu_cnt;
   bit mdu_armed;

   mdu_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .WDOG(WDOG)) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_src1    (req_src1),
      .req_src2    (req_src2),
      .req_tag     (req_tag),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_tag    (resp_tag),
      .resp_err    (resp_err),
      .m_op        (m_op),
      .m_src1      (m_src1),
      .m_src2      (m_src2),
      .m_flush     (m_flush),
      .m_ready     (mdu_ready),
      .m_result    (mdu_result)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Architectural RV64M result, including the divide-by-zero and overflow rules.
   function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [127:0]       sa, sb, za, zb, p;
      logic signed [63:0] qa, qb;
      logic               ovf;
      sa  = {{64{a[63]}}, a};
      sb  = {{64{b[63]}}, b};
      za  = {64'd0, a};
      zb  = {64'd0, b};
      qa  = a;
      qb  = b;
      ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
      ref_mdu = 64'd0;
      case (op)
         3'd0: begin p = za * zb; ref_mdu = p[63:0];   end
         3'd1: begin p = sa * sb; ref_mdu = p[127:64]; end
         3'd2: begin p = sa * zb; ref_mdu = p[127:64]; end
         3'd3: begin p = za * zb; ref_mdu = p[127:64]; end
         3'd4: ref_mdu = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf ? a : 64'(qa / qb));
         3'd5: ref_mdu = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
         3'd6: ref_mdu = (b == 0) ? a : (ovf ? 64'd0 : 64'(qa % qb));
         default: ref_mdu = (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [2:0] op_of(input logic [7:0] oh);
      op_of = 3'd0;
      for (int i = 0; i < 8; i++) if (oh[i]) op_of = 3'(i);
   endfunction

   // Behavioural MDU: sees the op, goes busy for mdu_lat-1 cycles, then reports
   // ready with the result. It will not restart until the op has been dropped.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mdu_ready  <= 1'b1;
         mdu_cnt    <= 0;
         mdu_armed  <= 1'b1;
         mdu_result <= '0;
      end else if (m_flush) begin
         mdu_ready <= 1'b1;
         mdu_cnt   <= 0;
         mdu_armed <= 1'b1;
      end else if (mdu_cnt != 0) begin
         if (!mdu_stuck) begin
            if (mdu_cnt == 1) begin
               mdu_ready  <= 1'b1;
               mdu_result <= ref_mdu(op_of(m_op), m_src1, m_src2);
            end
            mdu_cnt <= mdu_cnt - 1;
         end
      end else if (m_op != 8'd0) begin
         if (mdu_armed) begin
            mdu_ready  <= 1'b0;
            mdu_result <= 64'hBAD0_BAD0_BAD0_BAD0;
            mdu_cnt    <= mdu_lat - 1;
            mdu_armed  <= 1'b0;
         end
      end else begin
         mdu_armed <= 1'b1;
      end
   end

   task automatic do_req(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag, input int lat, input int bp, input bit stuck,
                         input string name);
      logic [63:0] exp_res;
      logic [7:0]  exp_op;
      bit          dz;
      int          exp_lat;
      int          k;
      dz      = op[2] && (b == 0);
      exp_res = stuck ? 64'd0 : ref_mdu(op, a, b);
      exp_op  = dz ? 8'd0 : (8'd1 << op);
      exp_lat = dz ? 1 : (stuck ? WDOG + 2 : lat + 2);
      mdu_lat   = lat;
      mdu_stuck = stuck;
      check_eq({name, ":req_ready_idle"}, req_ready, 1);
      req_valid  = 1'b1;
      req_op     = op;
      req_src1   = a;
      req_src2   = b;
      req_tag    = tag;
      resp_ready = (bp == 0);
      @(negedge clock);
      req_valid = 1'b0;
      req_src1  = {$urandom, $urandom};
      req_src2  = {$urandom, $urandom};
      req_tag   = 5'($urandom);
      k = 1;
      while (!resp_valid && k < exp_lat + 20) begin
         check_eq({name, ":mop_hold"}, m_op, exp_op);
         check_eq({name, ":src1_hold"}, m_src1, a);
         check_eq({name, ":src2_hold"}, m_src2, b);
         check_eq({name, ":req_ready_busy"}, req_ready, 0);
         check_eq({name, ":mflush_quiet"}, m_flush, 0);
         @(negedge clock);
         k++;
      end
      check_eq({name, ":latency"}, k, exp_lat);
      check_eq({name, ":resp_valid"}, resp_valid, 1);
      check_eq({name, ":result"}, resp_result, exp_res);
      check_eq({name, ":tag"}, resp_tag, tag);
      check_eq({name, ":err"}, resp_err, stuck);
      check_eq({name, ":mop_drop"}, m_op, 0);
      check_eq({name, ":mflush_resp"}, m_flush, stuck);
      for (int i = 1; i < bp; i++) begin
         @(negedge clock);
         check_eq({name, ":bp_valid"}, resp_valid, 1);
         check_eq({name, ":bp_result"}, resp_result, exp_res);
         check_eq({name, ":bp_tag"}, resp_tag, tag);
         check_eq({name, ":bp_req_ready"}, req_ready, 0);
         check_eq({name, ":bp_mflush"}, m_flush, 0);
      end
      resp_ready = 1'b1;
      @(negedge clock);
      check_eq({name, ":resp_drop"}, resp_valid, 0);
      check_eq({name, ":req_ready_after"}, req_ready, 1);
      check_eq({name, ":mflush_after"}, m_flush, 0);
      mdu_stuck = 1'b0;
   endtask

   initial begin
      logic [63:0] a, b;
      int          r;

      // Reset values
      repeat (2) @(negedge clock);
      check_eq("rst:req_ready", req_ready, 1);
      check_eq("rst:resp_valid", resp_valid, 0);
      check_eq("rst:resp_err", resp_err, 0);
      check_eq("rst:m_op", m_op, 0);
      check_eq("rst:m_flush", m_flush, 0);
      check_eq("rst:result", resp_result, 0);
      reset = 1'b1;
      @(negedge clock);
      check_eq("rst:req_ready_rel", req_ready, 1);

      // 1. mul 7 * -3, 4-cycle MDU
      do_req(3'd0, 64'd7, -64'sd3, 5'd9, 4, 0, 1'b0, "mul");
      // 2. divide by zero, local answer
      do_req(3'd5, 64'h1234, 64'd0, 5'd3, 4, 0, 1'b0, "divu0");
      do_req(3'd7, 64'h1234, 64'd0, 5'd4, 4, 0, 1'b0, "remu0");
      do_req(3'd4, 64'h55, 64'd0, 5'd5, 4, 2, 1'b0, "div0_bp");
      // 3. backpressure on rem 17,5
      do_req(3'd6, 64'd17, 64'd5, 5'd17, 3, 5, 1'b0, "rem_bp");

      // 4. flush while a div is busy
      mdu_lat    = 8;
      req_valid  = 1'b1;
      req_op     = 3'd4;
      req_src1   = 64'd100;
      req_src2   = 64'd7;
      req_tag    = 5'd1;
      @(negedge clock);
      req_valid = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("flush:mop_before", m_op, 8'h10);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check_eq("flush:mflush", m_flush, 1);
      check_eq("flush:mop", m_op, 0);
      check_eq("flush:idle", req_ready, 1);
      check_eq("flush:resp_valid", resp_valid, 0);
      @(negedge clock);
      check_eq("flush:mflush_pulse", m_flush, 0);
      repeat (10) begin
         @(negedge clock);
         check_eq("flush:no_resp", resp_valid, 0);
      end
      do_req(3'd3, 64'h8000_0000_0000_0000, 64'd4, 5'd30, 5, 0, 1'b0, "mulhu");

      // Request handshaked together with flush is discarded
      req_valid = 1'b1;
      req_op    = 3'd0;
      req_src1  = 64'd3;
      req_src2  = 64'd3;
      flush     = 1'b1;
      @(negedge clock);
      req_valid = 1'b0;
      flush     = 1'b0;
      check_eq("flushreq:idle", req_ready, 1);
      check_eq("flushreq:mop", m_op, 0);
      check_eq("flushreq:mflush", m_flush, 0);
      repeat (6) begin
         @(negedge clock);
         check_eq("flushreq:no_resp", resp_valid, 0);
      end

      // 5. stuck MDU -> watchdog abort
      do_req(3'd1, 64'd12345, 64'd678, 5'd22, 4, 0, 1'b1, "wdog");
      do_req(3'd2, -64'sd5, 64'd3, 5'd23, 2, 3, 1'b0, "mulhsu");

      // 6. async reset while busy
      mdu_lat   = 6;
      req_valid = 1'b1;
      req_op    = 3'd0;
      req_src1  = 64'd11;
      req_src2  = 64'd13;
      req_tag   = 5'd7;
      @(negedge clock);
      req_valid = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("arst:mop_before", m_op, 8'h01);
      #2 reset = 1'b0;
      #1;
      check_eq("arst:req_ready", req_ready, 1);
      check_eq("arst:resp_valid", resp_valid, 0);
      check_eq("arst:m_op", m_op, 0);
      check_eq("arst:m_flush", m_flush, 0);
      check_eq("arst:m_src1", m_src1, 0);
      check_eq("arst:tag", resp_tag, 0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_eq("arst:req_ready_rel", req_ready, 1);
      check_eq("arst:mflush_rel", m_flush, 0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 4);
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (r == 0) b = 64'd0;
         else if (r == 1) b = 64'($urandom_range(1, 9));
         else if (r == 2) begin
            a = 64'h8000_0000_0000_0000;
            b = 64'hFFFF_FFFF_FFFF_FFFF;
         end
         do_req(3'($urandom_range(0, 7)), a, b, 5'($urandom), $urandom_range(2, 6),
                $urandom_range(0, 3), 1'b0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=%0d exp=0", 1);
      $fatal(1);
   end

endmodule
